// File: rtl/miriscv_lsu_pkg.sv
// ---------------------------------------------------------------------------
// miriscv_lsu_pkg
// Types and constants for the load/store path, including the data-memory
// arbiter that shares the core data port between the LSU and an auxiliary
// master (debug module or DMA).
// ---------------------------------------------------------------------------
package miriscv_lsu_pkg;

  // Number of requesters sharing the data-memory port
  localparam int unsigned DMEM_REQ_N = 2;

  // Requester identifier carried by every accepted transaction
  typedef logic dmem_id_t;

  localparam dmem_id_t DMEM_ID_LSU = 1'b0;
  localparam dmem_id_t DMEM_ID_AUX = 1'b1;

  // Arbiter lock state: IDLE arbitrates freely, LOCKED holds one requester
  // on the bus until its request is granted.
  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } dmem_arb_state_e;

endpackage : miriscv_lsu_pkg

// File: rtl/miriscv_pkg.sv
// ---------------------------------------------------------------------------
// miriscv_pkg
// Core-wide constants shared by the miriscv blocks.
// ---------------------------------------------------------------------------
package miriscv_pkg;

  localparam int unsigned XLEN = 32;

endpackage : miriscv_pkg

// File: rtl/miriscv_dmem_id_fifo.sv
// ---------------------------------------------------------------------------
// miriscv_dmem_id_fifo
// Circular FIFO of requester IDs, one entry per accepted-but-unanswered
// data-memory transaction. Responses come back in order, so the head entry
// names the owner of the next response.
//
// Ports:
//   clk_i      core clock
//   arstn_i    asynchronous active-low reset (empties the FIFO)
//   push_i     store push_id_i at the tail
//   push_id_i  owner of the transaction being accepted
//   pop_i      drop the head entry (ignored while empty)
//   head_id_o  owner of the oldest outstanding transaction
//   count_o    number of outstanding transactions
//   full_o     DEPTH entries stored
// ---------------------------------------------------------------------------
module miriscv_dmem_id_fifo
  import miriscv_lsu_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             push_i,
  input  dmem_id_t         push_id_i,
  input  logic             pop_i,
  output dmem_id_t         head_id_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  dmem_id_t [DEPTH-1:0]   mem_q, mem_d;
  logic                   push_eff;
  logic                   pop_eff;

  // Pointers wrap modulo DEPTH, which need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  endfunction

  assign pop_eff  = pop_i & (count_q != '0);
  // A pop in the same cycle frees the slot the push needs
  assign push_eff = push_i & ((count_q != CNT_FULL) | pop_eff);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_eff) begin
      mem_d[wr_ptr_q] = push_id_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_eff) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ID storage is only read behind a non-zero count, so it needs no reset
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_id_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = (count_q == CNT_FULL);

endmodule : miriscv_dmem_id_fifo

// File: rtl/miriscv_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// miriscv_dmem_arbiter
// Shares the core data-memory port between the LSU (requester 0) and an
// auxiliary master (requester 1). A locked round-robin arbiter keeps the
// chosen request on the bus until it is granted; an owner FIFO routes the
// in-order responses back to the requester that issued each transaction.
//
// Ports:
//   clk_i, arstn_i         clock, asynchronous active-low reset
//   r_req_i/r_we_i/r_be_i  per-requester request, write enable, byte enables
//   r_addr_i/r_wdata_i     per-requester address and write data
//   r_gnt_o                per-requester grant (same cycle as data_gnt_i)
//   r_rvalid_o/r_rdata_o   per-requester response valid, shared read data
//   data_*_o               request to the external data bus
//   data_gnt_i             bus grant
//   data_rvalid_i/rdata_i  bus response
//   busy_o                 transactions outstanding or a request locked
//   rsp_err_o              response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module miriscv_dmem_arbiter
  import miriscv_lsu_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned XLEN      = miriscv_pkg::XLEN
) (
  input  logic                                clk_i,
  input  logic                                arstn_i,
  input  logic [DMEM_REQ_N-1:0]               r_req_i,
  input  logic [DMEM_REQ_N-1:0]               r_we_i,
  input  logic [DMEM_REQ_N-1:0][3:0]          r_be_i,
  input  logic [DMEM_REQ_N-1:0][XLEN-1:0]     r_addr_i,
  input  logic [DMEM_REQ_N-1:0][XLEN-1:0]     r_wdata_i,
  output logic [DMEM_REQ_N-1:0]               r_gnt_o,
  output logic [DMEM_REQ_N-1:0]               r_rvalid_o,
  output logic [XLEN-1:0]                     r_rdata_o,
  output logic                                data_req_o,
  output logic                                data_we_o,
  output logic [3:0]                          data_be_o,
  output logic [XLEN-1:0]                     data_addr_o,
  output logic [XLEN-1:0]                     data_wdata_o,
  input  logic                                data_gnt_i,
  input  logic                                data_rvalid_i,
  input  logic [XLEN-1:0]                     data_rdata_i,
  output logic                                busy_o,
  output logic                                rsp_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  dmem_arb_state_e  state_q, state_d;
  dmem_id_t         lock_id_q, lock_id_d;
  dmem_id_t         rr_q, rr_d;       // requester that wins the next conflict

  dmem_id_t         sel_id;
  logic             sel_req;
  logic             issue;
  logic             accept;
  logic             pop;
  logic             has_outst;
  logic             fifo_full;
  dmem_id_t         head_id;
  logic [CNT_W-1:0] fifo_count;

  // Requester selection: a locked requester owns the bus even if the other
  // one asserts; its request dropping while locked releases the lock.
  always_comb begin
    sel_id  = DMEM_ID_LSU;
    sel_req = 1'b0;
    if (state_q == ARB_LOCKED) begin
      sel_id  = lock_id_q;
      sel_req = r_req_i[lock_id_q];
    end else begin
      sel_req = |r_req_i;
      case (r_req_i)
        2'b11:   sel_id = rr_q;
        2'b10:   sel_id = DMEM_ID_AUX;
        default: sel_id = DMEM_ID_LSU;
      endcase
    end
  end

  // Issue is held back while the owner FIFO has no room; state is frozen then
  assign issue     = sel_req & ~fifo_full;
  assign accept    = issue & data_gnt_i;
  assign has_outst = (fifo_count != '0);
  assign pop       = data_rvalid_i & has_outst;

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_d      = rr_q;
    if (accept) begin
      rr_d = ~sel_id;
    end
    case (state_q)
      ARB_IDLE: begin
        if (issue && !data_gnt_i) begin
          state_d   = ARB_LOCKED;
          lock_id_d = sel_id;
        end
      end
      ARB_LOCKED: begin
        if (!sel_req || accept) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= ARB_IDLE;
      lock_id_q <= DMEM_ID_LSU;
      rr_q      <= DMEM_ID_LSU;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_q      <= rr_d;
    end
  end

  // Bus side: request fields are zero whenever nothing is issued
  always_comb begin
    data_req_o   = issue;
    data_we_o    = issue & r_we_i[sel_id];
    data_be_o    = issue ? r_be_i[sel_id]    : '0;
    data_addr_o  = issue ? r_addr_i[sel_id]  : '0;
    data_wdata_o = issue ? r_wdata_i[sel_id] : '0;
  end

  // Requester side: grant and response routing are both combinational
  always_comb begin
    r_gnt_o    = '0;
    r_rvalid_o = '0;
    if (accept) begin
      r_gnt_o[sel_id] = 1'b1;
    end
    if (pop) begin
      r_rvalid_o[head_id] = 1'b1;
    end
  end

  assign r_rdata_o = data_rdata_i;
  // A response with nothing outstanding (e.g. to a pre-reset request) is dropped
  assign rsp_err_o = data_rvalid_i & ~has_outst;
  assign busy_o    = has_outst | (state_q == ARB_LOCKED);

  miriscv_dmem_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .arstn_i   (arstn_i),
    .push_i    (accept),
    .push_id_i (sel_id),
    .pop_i     (pop),
    .head_id_o (head_id),
    .count_o   (fifo_count),
    .full_o    (fifo_full)
  );

endmodule : miriscv_dmem_arbiter

// File: tb/tb_miriscv_dmem_arbiter.sv
module tb_miriscv_dmem_arbiter;

  localparam int unsigned MAX_OUTST = 2;
  localparam int unsigned XLEN      = 32;

  logic                 clk_i = 1'b0;
  logic                 arstn_i;
  logic [1:0]           r_req_i;
  logic [1:0]           r_we_i;
  logic [1:0][3:0]      r_be_i;
  logic [1:0][XLEN-1:0] r_addr_i;
  logic [1:0][XLEN-1:0] r_wdata_i;
  logic [1:0]           r_gnt_o;
  logic [1:0]           r_rvalid_o;
  logic [XLEN-1:0]      r_rdata_o;
  logic                 data_req_o;
  logic                 data_we_o;
  logic [3:0]           data_be_o;
  logic [XLEN-1:0]      data_addr_o;
  logic [XLEN-1:0]      data_wdata_o;
  logic                 data_gnt_i;
  logic                 data_rvalid_i;
  logic [XLEN-1:0]      data_rdata_i;
  logic                 busy_o;
  logic                 rsp_err_o;

  miriscv_dmem_arbiter #(
    .MAX_OUTST (MAX_OUTST),
    .XLEN      (XLEN)
  ) dut (
    .clk_i         (clk_i),
    .arstn_i       (arstn_i),
    .r_req_i       (r_req_i),
    .r_we_i        (r_we_i),
    .r_be_i        (r_be_i),
    .r_addr_i      (r_addr_i),
    .r_wdata_i     (r_wdata_i),
    .r_gnt_o       (r_gnt_o),
    .r_rvalid_o    (r_rvalid_o),
    .r_rdata_o     (r_rdata_o),
    .data_req_o    (data_req_o),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_addr_o   (data_addr_o),
    .data_wdata_o  (data_wdata_o),
    .data_gnt_i    (data_gnt_i),
    .data_rvalid_i (data_rvalid_i),
    .data_rdata_i  (data_rdata_i),
    .busy_o        (busy_o),
    .rsp_err_o     (rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model state: owner queue, lock and conflict priority
  int q[$];
  bit m_locked;
  int m_lock_id;
  int m_prio;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge
  task automatic cyc(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rdata);
    r_req_i       = req;
    data_gnt_i    = gnt;
    data_rvalid_i = rv;
    data_rdata_i  = rdata;
    @(negedge clk_i);
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input bit check, input string tag);
    arstn_i       = 1'b0;
    r_req_i       = '0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
    q.delete();
    m_locked = 0;
    m_prio   = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    if (check) begin
      chk({tag, "_gnt"},    r_gnt_o,     0);
      chk({tag, "_rvalid"}, r_rvalid_o,  0);
      chk({tag, "_dreq"},   data_req_o,  0);
      chk({tag, "_daddr"},  data_addr_o, 0);
      chk({tag, "_busy"},   busy_o,      0);
      chk({tag, "_err"},    rsp_err_o,   0);
    end
    @(posedge clk_i);
    #1;
    arstn_i = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic        e_dreq;
    logic [31:0] e_addr;
    logic        e_err;
    logic        e_busy;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic [1:0] req, input logic gnt, input logic rv,
                              input logic [31:0] rdata, input logic [1:0] e_gnt,
                              input logic [1:0] e_rv, input logic e_dreq,
                              input logic [31:0] e_addr, input logic e_err, input logic e_busy);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_dreq = e_dreq; v.e_addr = e_addr;
    v.e_err = e_err; v.e_busy = e_busy;
    return v;
  endfunction

  initial begin
    r_we_i       = 2'b10;
    r_be_i[0]    = 4'hF;
    r_be_i[1]    = 4'h3;
    r_addr_i[0]  = 32'h0000_0100;
    r_addr_i[1]  = 32'h0000_0200;
    r_wdata_i[0] = 32'h1111_1111;
    r_wdata_i[1] = 32'h2222_2222;

    //             req    g     rv    rdata          gnt    rv     dreq  addr   err   busy
    // conflict with responses flowing back: grants alternate, owners tracked
    tbl[0]  = mk(2'b11, 1'b1, 1'b0, 32'h0,         2'b01, 2'b00, 1'b1, 32'h100, 1'b0, 1'b0);
    tbl[1]  = mk(2'b11, 1'b1, 1'b1, 32'hAAAA0001,  2'b10, 2'b01, 1'b1, 32'h200, 1'b0, 1'b1);
    tbl[2]  = mk(2'b11, 1'b1, 1'b1, 32'hAAAA0002,  2'b01, 2'b10, 1'b1, 32'h100, 1'b0, 1'b1);
    tbl[3]  = mk(2'b11, 1'b1, 1'b1, 32'hAAAA0003,  2'b10, 2'b01, 1'b1, 32'h200, 1'b0, 1'b1);
    tbl[4]  = mk(2'b00, 1'b0, 1'b1, 32'hAAAA0004,  2'b00, 2'b10, 1'b0, 32'h0,   1'b0, 1'b1);
    tbl[5]  = mk(2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 32'h0,   1'b0, 1'b0);
    // spurious response
    tbl[6]  = mk(2'b00, 1'b0, 1'b1, 32'hBAD0BAD0,  2'b00, 2'b00, 1'b0, 32'h0,   1'b1, 1'b0);
    tbl[7]  = mk(2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 32'h0,   1'b0, 1'b0);
    // single LSU read, response two cycles later
    tbl[8]  = mk(2'b01, 1'b1, 1'b0, 32'h0,         2'b01, 2'b00, 1'b1, 32'h100, 1'b0, 1'b0);
    tbl[9]  = mk(2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 32'h0,   1'b0, 1'b1);
    tbl[10] = mk(2'b00, 1'b0, 1'b1, 32'hDEADBEEF,  2'b00, 2'b01, 1'b0, 32'h0,   1'b0, 1'b1);
    tbl[11] = mk(2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 32'h0,   1'b0, 1'b0);

    do_reset(1'b1, "por");

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
      chk($sformatf("tbl%0d_gnt", i),    r_gnt_o,     tbl[i].e_gnt);
      chk($sformatf("tbl%0d_rvalid", i), r_rvalid_o,  tbl[i].e_rv);
      chk($sformatf("tbl%0d_dreq", i),   data_req_o,  tbl[i].e_dreq);
      chk($sformatf("tbl%0d_daddr", i),  data_addr_o, tbl[i].e_addr);
      chk($sformatf("tbl%0d_err", i),    rsp_err_o,   tbl[i].e_err);
      chk($sformatf("tbl%0d_busy", i),   busy_o,      tbl[i].e_busy);
      chk($sformatf("tbl%0d_rdata", i),  r_rdata_o,   tbl[i].rdata);
      nxt();
    end

    // Lock: port 1 held on the bus while port 0 joins, grant order 1 then 0
    do_reset(1'b0, "rst_lock");
    cyc(2'b10, 1'b0, 1'b0, 32'h0);
    chk("lock_c1_dreq", data_req_o, 1); chk("lock_c1_addr", data_addr_o, 32'h200);
    chk("lock_c1_gnt", r_gnt_o, 2'b00); chk("lock_c1_we", data_we_o, 1);
    nxt();
    cyc(2'b11, 1'b0, 1'b0, 32'h0);
    chk("lock_c2_addr", data_addr_o, 32'h200); chk("lock_c2_gnt", r_gnt_o, 2'b00);
    chk("lock_c2_busy", busy_o, 1); chk("lock_c2_be", data_be_o, 4'h3);
    nxt();
    cyc(2'b11, 1'b0, 1'b0, 32'h0);
    chk("lock_c3_addr", data_addr_o, 32'h200); chk("lock_c3_wdata", data_wdata_o, 32'h2222_2222);
    nxt();
    cyc(2'b11, 1'b1, 1'b0, 32'h0);
    chk("lock_c4_addr", data_addr_o, 32'h200); chk("lock_c4_gnt", r_gnt_o, 2'b10);
    nxt();
    cyc(2'b01, 1'b1, 1'b0, 32'h0);
    chk("lock_c5_addr", data_addr_o, 32'h100); chk("lock_c5_gnt", r_gnt_o, 2'b01);
    nxt();
    cyc(2'b00, 1'b0, 1'b1, 32'h5555_0001);
    chk("lock_rsp1", r_rvalid_o, 2'b10);
    nxt();
    cyc(2'b00, 1'b0, 1'b1, 32'h5555_0002);
    chk("lock_rsp2", r_rvalid_o, 2'b01);
    nxt();
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    chk("lock_idle_busy", busy_o, 0);
    nxt();

    // Full: third request waits for a slot freed by a response
    do_reset(1'b0, "rst_full");
    cyc(2'b01, 1'b1, 1'b0, 32'h0); chk("full_a1", r_gnt_o, 2'b01); nxt();
    cyc(2'b01, 1'b1, 1'b0, 32'h0); chk("full_a2", r_gnt_o, 2'b01); nxt();
    cyc(2'b01, 1'b1, 1'b0, 32'h0);
    chk("full_gated_dreq", data_req_o, 0); chk("full_gated_gnt", r_gnt_o, 2'b00);
    chk("full_gated_busy", busy_o, 1);
    nxt();
    cyc(2'b01, 1'b1, 1'b1, 32'h7777_0001);
    chk("full_pop_dreq", data_req_o, 0); chk("full_pop_rvalid", r_rvalid_o, 2'b01);
    nxt();
    cyc(2'b01, 1'b1, 1'b0, 32'h0);
    chk("full_a3_dreq", data_req_o, 1); chk("full_a3_gnt", r_gnt_o, 2'b01);
    nxt();

    // Reset with two outstanding, then a stale response
    do_reset(1'b1, "midrst");
    cyc(2'b00, 1'b0, 1'b1, 32'h9999_0001);
    chk("stale_rvalid", r_rvalid_o, 2'b00); chk("stale_err", rsp_err_o, 1);
    chk("stale_busy", busy_o, 0);
    nxt();
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    chk("stale_err_clear", rsp_err_o, 0);
    nxt();

    // Randomized traffic against the behavioural model
    do_reset(1'b0, "rst_rand");
    for (int k = 0; k < 400; k++) begin
      int          cand;
      bit          vld, issue, acc;
      logic [1:0]  e_gnt, e_rv;
      logic        e_err;
      logic [1:0]  req;
      logic        gnt, rv;
      req = 2'($urandom_range(0, 3));
      gnt = ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 2) == 0);
      r_we_i       = 2'($urandom_range(0, 3));
      r_be_i[0]    = 4'($urandom_range(0, 15));
      r_be_i[1]    = 4'($urandom_range(0, 15));
      r_addr_i[0]  = $urandom;
      r_addr_i[1]  = $urandom;
      r_wdata_i[0] = $urandom;
      r_wdata_i[1] = $urandom;
      cyc(req, gnt, rv, $urandom);

      if (m_locked) begin
        cand = m_lock_id;
        vld  = req[cand];
      end else if (req == 2'b11) begin
        cand = m_prio;
        vld  = 1;
      end else begin
        cand = req[1] ? 1 : 0;
        vld  = (req != 0);
      end
      issue = vld && (q.size() < MAX_OUTST);
      acc   = issue && gnt;
      e_gnt = acc ? (2'b01 << cand) : 2'b00;
      if (rv && q.size() > 0) begin
        e_rv  = 2'b01 << q[0];
        e_err = 0;
      end else begin
        e_rv  = 2'b00;
        e_err = rv;
      end

      chk($sformatf("rnd%0d_gnt", k),    r_gnt_o,      e_gnt);
      chk($sformatf("rnd%0d_rvalid", k), r_rvalid_o,   e_rv);
      chk($sformatf("rnd%0d_err", k),    rsp_err_o,    e_err);
      chk($sformatf("rnd%0d_busy", k),   busy_o,       (q.size() != 0) || m_locked);
      chk($sformatf("rnd%0d_dreq", k),   data_req_o,   issue);
      chk($sformatf("rnd%0d_addr", k),   data_addr_o,  issue ? r_addr_i[cand]  : 32'h0);
      chk($sformatf("rnd%0d_we", k),     data_we_o,    issue ? r_we_i[cand]    : 1'b0);
      chk($sformatf("rnd%0d_be", k),     data_be_o,    issue ? r_be_i[cand]    : 4'h0);
      chk($sformatf("rnd%0d_wdata", k),  data_wdata_o, issue ? r_wdata_i[cand] : 32'h0);
      chk($sformatf("rnd%0d_rdata", k),  r_rdata_o,    data_rdata_i);

      if (rv && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        q.push_back(cand);
        m_prio = 1 - cand;
      end
      if (m_locked) begin
        if (!vld || acc) m_locked = 0;
      end else if (issue && !gnt) begin
        m_locked  = 1;
        m_lock_id = cand;
      end
      nxt();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_miriscv_dmem_arbiter
